// File: rtl/ifmap_tx_pkg.sv
// Shared definitions for the IFmap stream transmitter: row tags, FSM states, tagged-word width.
package ifmap_tx_pkg;

  localparam logic [1:0] TAG_MID = 2'b00;
  localparam logic [1:0] TAG_EOR = 2'b01;
  localparam logic [1:0] TAG_SOR = 2'b10;
  localparam logic [1:0] TAG_SGL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } tx_state_e;

  // Width of a tagged IF buffer word: 2-bit row marker on top of the sample.
  function automatic int unsigned tagged_w(input int unsigned data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/ifmap_out_stage.sv
// One-entry holding register between the sample stream and the IF buffer write port.
module ifmap_out_stage #(
  parameter int unsigned W = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_discard,
  input  logic         i_full,
  output logic         o_valid,
  output logic         o_can_load,
  output logic         o_wen,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_drain;

  assign w_drain    = r_valid && !i_full;
  assign o_can_load = !r_valid || !i_full;
  assign o_valid    = r_valid;
  assign o_wen      = w_drain;
  assign o_data     = r_data;

  // Occupancy: a discard wins, a load refills (even while draining), otherwise a write empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else if (i_discard) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end
  end

  // Payload only changes on a load, so it stays stable while the buffer is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_load && !i_discard) begin
      r_data <= i_data;
    end
  end

endmodule

// File: rtl/ifmap_stream_tx.sv
// IFmap transmitter: tags raw samples with row markers and writes them to the IF buffer.
// Optional feature macro: IFTX_ABORT_EN adds the abort input and aborted pulse output.
module ifmap_stream_tx
  import ifmap_tx_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ROW_LEN_W = 6,
  parameter int unsigned ROW_CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ROW_LEN_W-1:0] row_len,
  input  logic [ROW_CNT_W-1:0] num_rows,
  input  logic                 s_valid,
  input  logic [DATA_W-1:0]    s_data,
  output logic                 s_ready,
  output logic                 IF_wen,
  output logic [DATA_W+1:0]    IF_din,
  input  logic                 IF_full,
  output logic                 busy,
  output logic                 done
`ifdef IFTX_ABORT_EN
  ,
  input  logic                 abort,
  output logic                 aborted
`endif
);

  localparam int unsigned TW = tagged_w(DATA_W);

  tx_state_e            r_state;
  tx_state_e            w_state_nxt;
  logic [ROW_LEN_W-1:0] r_row_len;
  logic [ROW_LEN_W-1:0] r_col_cnt;
  logic [ROW_CNT_W-1:0] r_num_rows;
  logic [ROW_CNT_W-1:0] r_row_cnt;
  logic                 w_cfg_ok;
  logic                 w_launch;
  logic                 w_can_load;
  logic                 w_out_valid;
  logic                 w_wen;
  logic                 w_accept;
  logic                 w_first_col;
  logic                 w_last_col;
  logic                 w_last_row;
  logic                 w_abort;
  logic [1:0]           w_tag;
  logic [TW-1:0]        w_word;
  logic [TW-1:0]        w_dout;

  assign w_cfg_ok    = (row_len != '0) && (num_rows != '0);
  assign w_launch    = (r_state == ST_IDLE) && start && w_cfg_ok;
  assign w_first_col = (r_col_cnt == '0);
  assign w_last_col  = (r_col_cnt == ROW_LEN_W'(r_row_len - ROW_LEN_W'(1)));
  assign w_last_row  = (r_row_cnt == ROW_CNT_W'(r_num_rows - ROW_CNT_W'(1)));

`ifdef IFTX_ABORT_EN
  logic r_aborted;
  assign w_abort = abort && ((r_state == ST_STREAM) || (r_state == ST_FLUSH));
  assign aborted = r_aborted;

  // One-cycle acknowledge of an abort that actually cancelled a transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_aborted <= 1'b0;
    end else begin
      r_aborted <= w_abort;
    end
  end
`else
  assign w_abort = 1'b0;
`endif

  assign s_ready  = (r_state == ST_STREAM) && w_can_load && !w_abort;
  assign w_accept = s_valid && s_ready;
  assign busy     = (r_state == ST_STREAM) || (r_state == ST_FLUSH);
  assign done     = (r_state == ST_DONE);
  assign IF_wen   = w_wen;
  assign IF_din   = w_dout;

  // Row marker from the column position; a one-sample row is both first and last.
  always_comb begin
    w_tag = TAG_MID;
    if (w_first_col && w_last_col) begin
      w_tag = TAG_SGL;
    end else if (w_first_col) begin
      w_tag = TAG_SOR;
    end else if (w_last_col) begin
      w_tag = TAG_EOR;
    end
    w_word = {w_tag, s_data};
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; FLUSH ends on the cycle the held word leaves so done follows the write directly.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = w_cfg_ok ? ST_STREAM : ST_DONE;
      ST_STREAM: if (w_accept && w_last_col && w_last_row) w_state_nxt = ST_FLUSH;
      ST_FLUSH:  if (!w_out_valid || w_wen) w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Transfer geometry latch and column/row position counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row_len  <= '0;
      r_num_rows <= '0;
      r_col_cnt  <= '0;
      r_row_cnt  <= '0;
    end else if (w_launch) begin
      r_row_len  <= row_len;
      r_num_rows <= num_rows;
      r_col_cnt  <= '0;
      r_row_cnt  <= '0;
    end else if (w_accept) begin
      if (w_last_col) begin
        r_col_cnt <= '0;
        r_row_cnt <= r_row_cnt + ROW_CNT_W'(1);
      end else begin
        r_col_cnt <= r_col_cnt + ROW_LEN_W'(1);
      end
    end
  end

  ifmap_out_stage #(
    .W (TW)
  ) u_out_stage (
    .clk        (clk),
    .rst_n      (rst),
    .i_load     (w_accept),
    .i_data     (w_word),
    .i_discard  (w_abort),
    .i_full     (IF_full),
    .o_valid    (w_out_valid),
    .o_can_load (w_can_load),
    .o_wen      (w_wen),
    .o_data     (w_dout)
  );

endmodule

// File: tb/tb_ifmap_stream_tx.sv
// Self-checking bench for ifmap_stream_tx against a queue-based tagging model.
module tb_ifmap_stream_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  row_len;
  logic [5:0]  num_rows;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic        IF_wen;
  logic [17:0] IF_din;
  logic        IF_full;
  logic        busy;
  logic        done;
`ifdef IFTX_ABORT_EN
  logic        abort;
  logic        aborted;
  int          abt_cyc[$];
`endif

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          basic_lat = 0;
  logic [17:0] wr_log[$];
  int          wr_cyc[$];
  int          acc_cyc[$];
  int          done_cyc[$];

  ifmap_stream_tx dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .row_len  (row_len),
    .num_rows (num_rows),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .IF_wen   (IF_wen),
    .IF_din   (IF_din),
    .IF_full  (IF_full),
    .busy     (busy),
    .done     (done)
`ifdef IFTX_ABORT_EN
    ,
    .abort    (abort),
    .aborted  (aborted)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the write port, the source handshake and done away from the active edge.
  always @(negedge clk) begin
    if (IF_wen) begin
      wr_log.push_back(IF_din);
      wr_cyc.push_back(cyc);
    end
    if (s_valid && s_ready) acc_cyc.push_back(cyc);
    if (done) done_cyc.push_back(cyc);
`ifdef IFTX_ABORT_EN
    if (aborted) abt_cyc.push_back(cyc);
`endif
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected tagged words: position in row decides the marker, sample is passed through.
  function automatic void build_model(input int rl, input int nr, input logic [15:0] smp[$],
                                      output logic [17:0] e[$]);
    logic [1:0] t;
    e = {};
    for (int i = 0; i < rl * nr; i++) begin
      t[1] = ((i % rl) == 0);
      t[0] = ((i % rl) == (rl - 1));
      e.push_back({t, smp[i]});
    end
  endfunction

  task automatic do_start(input int rl, input int nr);
    @(posedge clk); #1;
    row_len  = 6'(rl);
    num_rows = 6'(nr);
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  // Offer samples in order; gap_pct is the chance of idling s_valid, stop_at > 0 stops after that many writes.
  task automatic feed(input logic [15:0] smp[$], input int gap_pct, input int stop_at,
                      input int wbase, output bit ok);
    int idx;
    int guard;
    bit hit;
    idx = 0;
    guard = 0;
    ok = 1'b1;
    while (idx < smp.size()) begin
      if (stop_at > 0 && wr_log.size() >= wbase + stop_at) break;
      if (guard > 2000) begin
        ok = 1'b0;
        break;
      end
      s_valid = (int'($urandom_range(99)) >= gap_pct);
      s_data  = s_valid ? smp[idx] : 16'($urandom);
      @(negedge clk);
      hit = s_valid && s_ready;
      @(posedge clk); #1;
      if (hit) idx++;
      guard++;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input int db, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk); #1;
      if (done_cyc.size() > db) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic make_plan_stream(output logic [15:0] q[$]);
    int v[12] = '{14, 39, 164, 171, -6, -80, 122, 9, 155, -51, -26, 147};
    q = {};
    for (int i = 0; i < 12; i++) q.push_back(16'(v[i]));
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; row_len = '0; num_rows = '0;
    s_valid = 1'b0; s_data = '0; IF_full = 1'b0;
`ifdef IFTX_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({s_ready, IF_wen, busy, done} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_ctrl: {s_ready,IF_wen,busy,done}=%b required 0000", {s_ready, IF_wen, busy, done});
    end
    n_vec++;
    if (IF_din !== 18'h0) begin
      n_bad++;
      $display("FAIL reset_din: IF_din=%h required 00000", IF_din);
    end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [15:0] q[$];
    logic [17:0] e[$];
    int wb, db, sc;
    bit ok;
    make_plan_stream(q);
    build_model(6, 2, q, e);
    wb = wr_log.size(); db = done_cyc.size();
    do_start(6, 2);
    sc = cyc;
    n_vec++;
    if (s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_start_ready: s_ready=%b required 1", s_ready);
    end
    feed(q, 0, 0, wb, ok);
    wait_done(db, 30, ok);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL basic_done_timeout: done not seen, required within 30 cycles");
    end
    n_vec++;
    if (wr_log.size() - wb !== 12) begin
      n_bad++;
      $display("FAIL basic_count: writes=%0d required 12", wr_log.size() - wb);
    end
    for (int i = 0; i < 12; i++) begin
      if (wb + i < wr_log.size()) begin
        n_vec++;
        if (wr_log[wb + i] !== e[i]) begin
          n_bad++;
          $display("FAIL basic_word%0d: IF_din=%h required %h", i, wr_log[wb + i], e[i]);
        end
      end
    end
    if (wr_log.size() >= wb + 12) begin
      n_vec++;
      if (wr_cyc[wb + 11] - wr_cyc[wb] !== 11) begin
        n_bad++;
        $display("FAIL basic_throughput: span=%0d cycles required 11", wr_cyc[wb + 11] - wr_cyc[wb]);
      end
    end
    if (ok) begin
      n_vec++;
      if (done_cyc[db] - acc_cyc[acc_cyc.size() - 1] !== 2) begin
        n_bad++;
        $display("FAIL basic_done_latency: %0d cycles required 2", done_cyc[db] - acc_cyc[acc_cyc.size() - 1]);
      end
      basic_lat = done_cyc[db] - sc;
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_done_pulse: done=%b one cycle later, required 0", done);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] q[$];
    logic [17:0] e[$];
    int wb, db, sc;
    bit ok, okd, seen;
    make_plan_stream(q);
    build_model(6, 2, q, e);
    wb = wr_log.size(); db = done_cyc.size();
    do_start(6, 2);
    sc = cyc;
    fork
      feed(q, 0, 0, wb, ok);
      begin
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk); #1;
          if (wr_log.size() >= wb + 3) begin
            seen = 1'b1;
            break;
          end
        end
        @(posedge clk); #1;
        IF_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          n_vec++;
          if ({IF_wen, IF_din} !== {1'b0, e[3]}) begin
            n_bad++;
            $display("FAIL bp_hold%0d: IF_wen=%b IF_din=%h required 0 %h seen3=%b", k, IF_wen, IF_din, e[3], seen);
          end
        end
        @(posedge clk); #1;
        IF_full = 1'b0;
      end
    join
    wait_done(db, 40, okd);
    n_vec++;
    if (wr_log.size() - wb !== 12) begin
      n_bad++;
      $display("FAIL bp_count: writes=%0d required 12", wr_log.size() - wb);
    end
    for (int i = 0; i < 12; i++) begin
      if (wb + i < wr_log.size()) begin
        n_vec++;
        if (wr_log[wb + i] !== e[i]) begin
          n_bad++;
          $display("FAIL bp_word%0d: IF_din=%h required %h", i, wr_log[wb + i], e[i]);
        end
      end
    end
    n_vec++;
    if (!okd || (done_cyc[db] - sc !== basic_lat + 3)) begin
      n_bad++;
      $display("FAIL bp_done_delay: done_seen=%b latency=%0d required %0d", okd,
               okd ? done_cyc[db] - sc : -1, basic_lat + 3);
    end
  endtask

  task automatic test_single_sample_rows();
    logic [15:0] q[$];
    logic [17:0] e[$];
    int wb, db;
    bit ok;
    q = {16'd5, 16'd6, 16'd7};
    build_model(1, 3, q, e);
    wb = wr_log.size(); db = done_cyc.size();
    do_start(1, 3);
    feed(q, 0, 0, wb, ok);
    wait_done(db, 30, ok);
    n_vec++;
    if (wr_log.size() - wb !== 3) begin
      n_bad++;
      $display("FAIL sgl_count: writes=%0d required 3", wr_log.size() - wb);
    end
    for (int i = 0; i < 3; i++) begin
      if (wb + i < wr_log.size()) begin
        n_vec++;
        if (wr_log[wb + i] !== e[i]) begin
          n_bad++;
          $display("FAIL sgl_word%0d: IF_din=%h required %h", i, wr_log[wb + i], e[i]);
        end
      end
    end
  endtask

  task automatic test_degenerate_and_restart();
    logic [15:0] q[$];
    logic [17:0] e[$];
    int wb, db;
    bit ok, okd;
    wb = wr_log.size(); db = done_cyc.size();
    do_start(4, 0);
    @(negedge clk);
    n_vec++;
    if ({done, busy} !== 2'b10) begin
      n_bad++;
      $display("FAIL degen_done: {done,busy}=%b required 10", {done, busy});
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL degen_done_pulse: done=%b required 0", done);
    end
    repeat (3) @(negedge clk);
    #1;
    n_vec++;
    if (wr_log.size() !== wb) begin
      n_bad++;
      $display("FAIL degen_no_write: writes=%0d required 0", wr_log.size() - wb);
    end
    q = {};
    for (int i = 0; i < 6; i++) q.push_back(16'($urandom));
    build_model(3, 2, q, e);
    wb = wr_log.size(); db = done_cyc.size();
    do_start(3, 2);
    fork
      feed(q, 0, 0, wb, ok);
      begin
        for (int i = 0; i < 50; i++) begin
          @(negedge clk); #1;
          if (wr_log.size() >= wb + 2) break;
        end
        row_len = 6'd5; num_rows = 6'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    wait_done(db, 40, okd);
    n_vec++;
    if (!okd || (wr_log.size() - wb !== 6)) begin
      n_bad++;
      $display("FAIL busy_start_ignored: done_seen=%b writes=%0d required 1 and 6", okd, wr_log.size() - wb);
    end
    for (int i = 0; i < 6; i++) begin
      if (wb + i < wr_log.size()) begin
        n_vec++;
        if (wr_log[wb + i] !== e[i]) begin
          n_bad++;
          $display("FAIL restart_word%0d: IF_din=%h required %h", i, wr_log[wb + i], e[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] q[$];
    logic [17:0] e[$];
    int wb, db;
    bit ok;
    make_plan_stream(q);
    build_model(6, 2, q, e);
    wb = wr_log.size();
    do_start(6, 2);
    feed(q, 0, 3, wb, ok);
    rst = 1'b0;
    #1;
    n_vec++;
    if ({IF_wen, busy, s_ready, IF_din} !== 21'h0) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: IF_wen=%b busy=%b s_ready=%b IF_din=%h required all 0",
               IF_wen, busy, s_ready, IF_din);
    end
    @(posedge clk); #1;
    @(negedge clk); #1;
    n_vec++;
    if (wr_log.size() - wb !== 3) begin
      n_bad++;
      $display("FAIL rst_mid_count: writes=%0d required 3", wr_log.size() - wb);
    end
    rst = 1'b1;
    wb = wr_log.size(); db = done_cyc.size();
    do_start(6, 2);
    feed(q, 0, 0, wb, ok);
    wait_done(db, 30, ok);
    n_vec++;
    if (wr_log.size() - wb !== 12) begin
      n_bad++;
      $display("FAIL rst_restart_count: writes=%0d required 12", wr_log.size() - wb);
    end
    for (int i = 0; i < 12; i++) begin
      if (wb + i < wr_log.size()) begin
        n_vec++;
        if (wr_log[wb + i] !== e[i]) begin
          n_bad++;
          $display("FAIL rst_restart_word%0d: IF_din=%h required %h", i, wr_log[wb + i], e[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] q[$];
    logic [17:0] e[$];
    int wb, db, rl, nr;
    bit ok, okd, stop;
    for (int it = 0; it < 6; it++) begin
      rl = int'($urandom_range(7, 1));
      nr = int'($urandom_range(4, 1));
      q = {};
      for (int i = 0; i < rl * nr; i++) q.push_back(16'($urandom));
      build_model(rl, nr, q, e);
      wb = wr_log.size(); db = done_cyc.size();
      stop = 1'b0;
      do_start(rl, nr);
      fork
        begin
          feed(q, 30, 0, wb, ok);
          wait_done(db, 300, okd);
          stop = 1'b1;
        end
        begin
          while (!stop) begin
            @(posedge clk); #1;
            IF_full = ($urandom_range(2) == 0);
          end
          IF_full = 1'b0;
        end
      join
      repeat (3) @(negedge clk);
      #1;
      n_vec++;
      if (!ok || !okd || (done_cyc.size() - db !== 1) || (wr_log.size() - wb !== rl * nr)) begin
        n_bad++;
        $display("FAIL rnd%0d_shape: fed=%b done=%b pulses=%0d writes=%0d required 1 1 1 %0d",
                 it, ok, okd, done_cyc.size() - db, wr_log.size() - wb, rl * nr);
      end
      for (int i = 0; i < rl * nr; i++) begin
        if (wb + i < wr_log.size()) begin
          n_vec++;
          if (wr_log[wb + i] !== e[i]) begin
            n_bad++;
            $display("FAIL rnd%0d_word%0d: IF_din=%h required %h (rl=%0d nr=%0d)", it, i, wr_log[wb + i], e[i], rl, nr);
          end
        end
      end
    end
  endtask

`ifdef IFTX_ABORT_EN
  task automatic test_abort();
    logic [15:0] q[$];
    logic [17:0] e[$];
    int wb, db, ab, nw;
    bit ok;
    make_plan_stream(q);
    build_model(6, 2, q, e);
    wb = wr_log.size(); db = done_cyc.size(); ab = abt_cyc.size();
    do_start(6, 2);
    feed(q, 0, 5, wb, ok);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    nw = wr_log.size();
    repeat (6) @(negedge clk);
    #1;
    n_vec++;
    if (wr_log.size() !== nw || nw - wb > 6) begin
      n_bad++;
      $display("FAIL abort_writes: writes=%0d then %0d required no growth and at most 6", nw - wb, wr_log.size() - wb);
    end
    n_vec++;
    if ((abt_cyc.size() - ab !== 1) || (done_cyc.size() !== db) || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_flags: aborted_pulses=%0d done_pulses=%0d busy=%b required 1 0 0",
               abt_cyc.size() - ab, done_cyc.size() - db, busy);
    end
    for (int i = 0; i < 5; i++) begin
      if (wb + i < wr_log.size()) begin
        n_vec++;
        if (wr_log[wb + i] !== e[i]) begin
          n_bad++;
          $display("FAIL abort_word%0d: IF_din=%h required %h", i, wr_log[wb + i], e[i]);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_single_sample_rows();
    test_degenerate_and_restart();
    test_reset_mid();
    test_random();
`ifdef IFTX_ABORT_EN
    test_abort();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
